mult_arbiter: RTL

Round-robin arbiter and sequencer that shares one shift-add multiplier between two requesters. It accepts an operand pair from the winning requester and latches it onto the multiplier inputs. It then pulses the multiplier start, waits for its Done, and returns the product with a per-requester ready pulse. It sits between the CPU-side requesters and the multiplier `CONTROL`/datapath; a watchdog aborts a transaction if Done never arrives.

---
 rtl/mult_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one shift-add multiplier between two requesters,
// with a watchdog that aborts a transaction whose Done never arrives.
module mult_arbiter #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Req0,
  input  logic               Req1,
  input  logic [WIDTH-1:0]   A0,
  input  logic [WIDTH-1:0]   B0,
  input  logic [WIDTH-1:0]   A1,
  input  logic [WIDTH-1:0]   B1,
  output logic               Gnt0,
  output logic               Gnt1,
  output logic               Rdy0,
  output logic               Rdy1,
  output logic               Err,
  output logic [2*WIDTH-1:0] Prod,
  output logic               Busy,
  output logic               Mul_St,
  output logic [WIDTH-1:0]   Mul_A,
  output logic [WIDTH-1:0]   Mul_B,
  input  logic               Mul_Idle,
  input  logic               Mul_Done,
  input  logic [2*WIDTH-1:0] Mul_Prod
);

  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                rdy0_q, rdy0_d, rdy1_q, rdy1_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                mul_st_q, mul_st_d;
  logic [WIDTH-1:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [2*WIDTH-1:0]  prod_q, prod_d;
  logic                win;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    timer_d  = timer_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    rdy0_d   = rdy0_q;
    rdy1_d   = rdy1_q;
    err_d    = err_q;
    busy_d   = busy_q;
    mul_st_d = mul_st_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    prod_d   = prod_q;
    // Contention goes to whoever was not served last.
    win      = (Req0 & Req1) ? ~last_q : Req1;

    unique case (state_q)
      StIdle: begin
        if ((Req0 | Req1) & Mul_Idle) begin
          owner_d  = win;
          mul_a_d  = win ? A1 : A0;
          mul_b_d  = win ? B1 : B0;
          gnt0_d   = ~win;
          gnt1_d   = win;
          mul_st_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        mul_st_d = 1'b0;
        timer_d  = '0;
        state_d  = StWait;
      end
      StWait: begin
        if (Mul_Done) begin
          prod_d  = Mul_Prod;
          rdy0_d  = ~owner_q;
          rdy1_d  = owner_q;
          state_d = StDone;
        end else if (timer_q == TimerMax) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StDone: begin
        rdy0_d  = 1'b0;
        rdy1_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      timer_q  <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rdy0_q   <= 1'b0;
      rdy1_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      mul_st_q <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rdy0_q   <= rdy0_d;
      rdy1_q   <= rdy1_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      mul_st_q <= mul_st_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      prod_q   <= prod_d;
    end
  end

  assign Gnt0   = gnt0_q;
  assign Gnt1   = gnt1_q;
  assign Rdy0   = rdy0_q;
  assign Rdy1   = rdy1_q;
  assign Err    = err_q;
  assign Busy   = busy_q;
  assign Mul_St = mul_st_q;
  assign Mul_A  = mul_a_q;
  assign Mul_B  = mul_b_q;
  assign Prod   = prod_q;

endmodule
